rgb_pwm: RTL

- Memory-mapped RGB LED PWM controller on the tst_6502 CPU bus.
- Drives the PWM inputs of the SB_RGBA_DRV instance at top level, replacing the static gpio_o[7:5] LED hookup.
- Provides per-channel 8-bit duty, a programmable period prescaler, glitch-free shadowed duty updates and a hardware "breathe" fade state machine.
- Runs in the 16 MHz CPU clock domain.

---
 rtl/rgb_pwm.sv | 133 +++++++++++++
 1 files changed

// File: rtl/rgb_pwm.sv
// rgb_pwm: memory-mapped RGB LED PWM controller with shadowed duties, prescaler and breathe fade
module rgb_pwm #(
    parameter logic [7:0] PSC_RESET  = 8'h00,
    parameter int         LEVEL_STEP = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs,
    input  logic       we,
    input  logic [2:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       pwm_r,
    output logic       pwm_g,
    output logic       pwm_b
);
    localparam logic [8:0] STEP = 9'(LEVEL_STEP);

    logic [2:0][7:0] shd_q, shd_d, act_q, act_d;
    logic [1:0]      ctrl_q, ctrl_d;
    logic [7:0]      psc_q, psc_d, pre_q, pre_d, cnt_q, cnt_d;
    logic [7:0]      lvl_q, lvl_d, dout_q, dout_d, rdata;
    logic            dir_q, dir_d, pend_q, pend_d;
    logic [2:0]      pwm_q, pwm_d;
    logic            en, br, tick, wrap, duty_wr, ctrl_wr, br_rise, up_sat, dn_sat;
    logic [8:0]      up_sum;

    // Scaled duty: a*(l+1)>>8 so that level 255 passes the duty through unchanged
    function automatic logic [7:0] eff(input logic [7:0] a, input logic [7:0] l);
        logic [15:0] p;
        p = 16'(a) * 16'(l) + 16'(a);
        return 8'(p >> 8);
    endfunction

    assign en      = ctrl_q[0];
    assign br      = ctrl_q[1];
    assign tick    = en && (pre_q >= psc_q);
    assign wrap    = tick && (cnt_q == 8'hFF);
    assign duty_wr = cs && we && (addr <= 3'd2);
    assign ctrl_wr = cs && we && (addr == 3'd3);
    assign br_rise = ctrl_wr && din[1] && !br;
    assign up_sum  = {1'b0, lvl_q} + STEP;
    assign up_sat  = up_sum >= 9'd255;
    assign dn_sat  = {1'b0, lvl_q} <= STEP;

    // Register file, prescaler, PWM counter and shadow-to-active transfer
    always_comb begin
        shd_d = shd_q;
        if (duty_wr) shd_d[addr[1:0]] = din;
        ctrl_d = ctrl_wr ? din[1:0] : ctrl_q;
        psc_d  = (cs && we && addr == 3'd4) ? din : psc_q;
        pre_d  = (!en || tick) ? 8'd0 : pre_q + 8'd1;
        cnt_d  = !en ? 8'd0 : cnt_q + {7'd0, tick};
        act_d  = (!en || (wrap && pend_q)) ? shd_q : act_q;
        pend_d = duty_wr ? 1'b1 : (!en || wrap) ? 1'b0 : pend_q;
        pwm_d  = {en && (cnt_q < eff(act_q[2], lvl_q)),
                  en && (cnt_q < eff(act_q[1], lvl_q)),
                  en && (cnt_q < eff(act_q[0], lvl_q))};
    end

    // Read mux; dout only updates on a read strobe
    always_comb begin
        case (addr)
            3'd0, 3'd1, 3'd2: rdata = shd_q[addr[1:0]];
            3'd3:             rdata = {6'd0, ctrl_q};
            3'd4:             rdata = psc_q;
            3'd5:             rdata = {6'd0, dir_q, pend_q};
            3'd6:             rdata = lvl_q;
            default:          rdata = 8'd0;
        endcase
        dout_d = (cs && !we) ? rdata : dout_q;
    end

    // Breathe next state: restart from dark on enable, otherwise step per wrap with saturation
    always_comb begin
        lvl_d = lvl_q;
        dir_d = dir_q;
        if (br_rise) begin
            lvl_d = 8'd0;
            dir_d = 1'b0;
        end else if (!br) begin
            lvl_d = 8'hFF;
            dir_d = 1'b0;
        end else if (wrap && !dir_q) begin
            lvl_d = up_sat ? 8'hFF : up_sum[7:0];
            dir_d = up_sat;
        end else if (wrap) begin
            lvl_d = dn_sat ? 8'h00 : lvl_q - STEP[7:0];
            dir_d = !dn_sat;
        end
    end

    // Breathe state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lvl_q <= 8'hFF;
            dir_q <= 1'b0;
        end else begin
            lvl_q <= lvl_d;
            dir_q <= dir_d;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shd_q  <= '0;
            act_q  <= '0;
            ctrl_q <= 2'd0;
            psc_q  <= PSC_RESET;
            pre_q  <= 8'd0;
            cnt_q  <= 8'd0;
            pend_q <= 1'b0;
            dout_q <= 8'd0;
            pwm_q  <= 3'd0;
        end else begin
            shd_q  <= shd_d;
            act_q  <= act_d;
            ctrl_q <= ctrl_d;
            psc_q  <= psc_d;
            pre_q  <= pre_d;
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            dout_q <= dout_d;
            pwm_q  <= pwm_d;
        end
    end

    assign dout  = dout_q;
    assign pwm_r = pwm_q[0];
    assign pwm_g = pwm_q[1];
    assign pwm_b = pwm_q[2];
endmodule
